// File: rtl/svc_rv_trace_fifo.sv
// rtl/svc_rv_trace_fifo.sv - retirement trace FIFO for the svc_rv RVFI port
//
// Purpose: captures each retired instruction reported on the RVFI port into a
// first-word-fall-through FIFO and drains it through a valid/ready stream.
// Counts retirements lost to a full FIFO and stops capturing after a halt.
//
// Optional feature macro: SVC_RV_TRACE_ORDER_CHECK_EN
//   defined   - order continuity checker drives order_err
//   undefined - checker removed, order_err tied to 0
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              synchronous clear of FIFO and status
//   rvfi_*             retirement record from the core
//   m_valid/m_ready    output stream handshake
//   m_*                payload of the entry at the head (0 when empty)
//   count              occupancy 0..DEPTH
//   dropped            saturating count of retirements lost while full
//   halted             sticky, set when a halt entry is accepted
//   order_err          sticky order-discontinuity flag
module svc_rv_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          rvfi_valid,
  input  logic [63:0]   rvfi_order,
  input  logic [31:0]   rvfi_insn,
  input  logic [31:0]   rvfi_pc_rdata,
  input  logic [4:0]    rvfi_rd_addr,
  input  logic [31:0]   rvfi_rd_wdata,
  input  logic          rvfi_trap,
  input  logic          rvfi_halt,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [63:0]   m_order,
  output logic [31:0]   m_insn,
  output logic [31:0]   m_pc,
  output logic [4:0]    m_rd_addr,
  output logic [31:0]   m_rd_wdata,
  output logic          m_trap,
  output logic          m_halt,
  output logic [CW-1:0] count,
  output logic [31:0]   dropped,
  output logic          halted,
  output logic          order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage is deliberately not reset.
  logic [63:0] mem_order    [DEPTH];
  logic [31:0] mem_insn     [DEPTH];
  logic [31:0] mem_pc       [DEPTH];
  logic [4:0]  mem_rd_addr  [DEPTH];
  logic [31:0] mem_rd_wdata [DEPTH];
  logic        mem_trap     [DEPTH];
  logic        mem_halt     [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   dropped_q, dropped_d;
  logic          halted_q, halted_d;

  logic pop;
  logic push;
  logic drop;

  assign m_valid = (count_q != '0);

  // A clear cycle discards both sides of the FIFO traffic.
  assign pop  = m_valid && m_ready && !clear;
  // Full FIFO still accepts when the head leaves on the same edge.
  assign push = rvfi_valid && !clear && !halted_q && ((count_q != DEPTH_C) || pop);
  assign drop = rvfi_valid && !clear && !halted_q && !push;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    halted_d  = halted_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = '0;
      halted_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (drop && (dropped_q != 32'hFFFF_FFFF)) begin
        dropped_d = dropped_q + 32'd1;
      end
      if (push && rvfi_halt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      halted_q  <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_order[wr_ptr_q]    <= rvfi_order;
      mem_insn[wr_ptr_q]     <= rvfi_insn;
      mem_pc[wr_ptr_q]       <= rvfi_pc_rdata;
      mem_rd_addr[wr_ptr_q]  <= rvfi_rd_addr;
      mem_rd_wdata[wr_ptr_q] <= rvfi_rd_wdata;
      mem_trap[wr_ptr_q]     <= rvfi_trap;
      mem_halt[wr_ptr_q]     <= rvfi_halt;
    end
  end

  // Payload is forced to zero while empty so stale RAM never leaks out.
  assign m_order    = m_valid ? mem_order[rd_ptr_q]    : 64'd0;
  assign m_insn     = m_valid ? mem_insn[rd_ptr_q]     : 32'd0;
  assign m_pc       = m_valid ? mem_pc[rd_ptr_q]       : 32'd0;
  assign m_rd_addr  = m_valid ? mem_rd_addr[rd_ptr_q]  : 5'd0;
  assign m_rd_wdata = m_valid ? mem_rd_wdata[rd_ptr_q] : 32'd0;
  assign m_trap     = m_valid ? mem_trap[rd_ptr_q]     : 1'b0;
  assign m_halt     = m_valid ? mem_halt[rd_ptr_q]     : 1'b0;

  assign count   = count_q;
  assign dropped = dropped_q;
  assign halted  = halted_q;

`ifdef SVC_RV_TRACE_ORDER_CHECK_EN
  logic [63:0] last_order_q, last_order_d;
  logic        have_last_q, have_last_d;
  logic        order_err_q, order_err_d;
  logic        seen;

  // Dropped retirements still advance the expected order, so an overflow
  // is not misreported as a discontinuity.
  assign seen = rvfi_valid && !clear && !halted_q;

  always_comb begin
    last_order_d = last_order_q;
    have_last_d  = have_last_q;
    order_err_d  = order_err_q;
    if (clear) begin
      have_last_d = 1'b0;
      order_err_d = 1'b0;
    end else if (seen) begin
      if (have_last_q && (rvfi_order != (last_order_q + 64'd1))) begin
        order_err_d = 1'b1;
      end
      last_order_d = rvfi_order;
      have_last_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_order_q <= '0;
      have_last_q  <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      last_order_q <= last_order_d;
      have_last_q  <= have_last_d;
      order_err_q  <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_svc_rv_trace_fifo.sv
// tb/tb_svc_rv_trace_fifo.sv - self-checking bench for svc_rv_trace_fifo
module tb_svc_rv_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
`ifdef SVC_RV_TRACE_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          rvfi_valid = 1'b0;
  logic [63:0]   rvfi_order = '0;
  logic [31:0]   rvfi_insn = '0;
  logic [31:0]   rvfi_pc_rdata = '0;
  logic [4:0]    rvfi_rd_addr = '0;
  logic [31:0]   rvfi_rd_wdata = '0;
  logic          rvfi_trap = 1'b0;
  logic          rvfi_halt = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [63:0]   m_order;
  logic [31:0]   m_insn;
  logic [31:0]   m_pc;
  logic [4:0]    m_rd_addr;
  logic [31:0]   m_rd_wdata;
  logic          m_trap;
  logic          m_halt;
  logic [CW-1:0] count;
  logic [31:0]   dropped;
  logic          halted;
  logic          order_err;

  svc_rv_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .m_valid(m_valid), .m_ready(m_ready), .m_order(m_order), .m_insn(m_insn),
    .m_pc(m_pc), .m_rd_addr(m_rd_addr), .m_rd_wdata(m_rd_wdata),
    .m_trap(m_trap), .m_halt(m_halt), .count(count), .dropped(dropped),
    .halted(halted), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
  } ent_t;

  typedef struct {
    bit          v;
    logic [63:0] ord;
    bit          h;
    bit          rdy;
    bit          clr;
    int          e_count;
    int          e_dropped;
    bit          e_halted;
    bit          e_mvalid;
    logic [63:0] e_morder;
  } vec_t;

  // Reference model state
  ent_t        md_q[$];
  logic [31:0] md_dropped;
  bit          md_halted;
  bit          md_oerr;
  bit          md_have;
  logic [63:0] md_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    md_q.delete();
    md_dropped = '0;
    md_halted  = 1'b0;
    md_oerr    = 1'b0;
    md_have    = 1'b0;
    md_last    = '0;
  endtask

  task automatic compare_all();
    ent_t e;
    e = '{default: '0};
    if (md_q.size() != 0) e = md_q[0];
    check("m_valid",    64'(m_valid),    64'(md_q.size() != 0));
    check("count",      64'(count),      64'(md_q.size()));
    check("dropped",    64'(dropped),    64'(md_dropped));
    check("halted",     64'(halted),     64'(md_halted));
    check("order_err",  64'(order_err),  64'(md_oerr));
    check("m_order",    m_order,         e.order);
    check("m_insn",     64'(m_insn),     64'(e.insn));
    check("m_pc",       64'(m_pc),       64'(e.pc));
    check("m_rd_addr",  64'(m_rd_addr),  64'(e.rd_addr));
    check("m_rd_wdata", 64'(m_rd_wdata), 64'(e.rd_wdata));
    check("m_trap",     64'(m_trap),     64'(e.trap));
    check("m_halt",     64'(m_halt),     64'(e.halt));
  endtask

  // Advance the model from the current inputs, clock once, then compare.
  task automatic step();
    bit   mv, pop, push, seen;
    ent_t e;
    mv   = (md_q.size() != 0);
    pop  = mv && m_ready && !clear;
    seen = rvfi_valid && !clear && !md_halted;
    push = seen && ((md_q.size() < DEPTH) || pop);
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(md_q.pop_front());
      if (push) begin
        e.order = rvfi_order;  e.insn = rvfi_insn;  e.pc = rvfi_pc_rdata;
        e.rd_addr = rvfi_rd_addr;  e.rd_wdata = rvfi_rd_wdata;
        e.trap = rvfi_trap;  e.halt = rvfi_halt;
        md_q.push_back(e);
        if (rvfi_halt) md_halted = 1'b1;
      end else if (seen && md_dropped != 32'hFFFF_FFFF) begin
        md_dropped = md_dropped + 1;
      end
      if (seen) begin
        if (CHK && md_have && rvfi_order != md_last + 64'd1) md_oerr = 1'b1;
        md_last = rvfi_order;
        md_have = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] ord, input bit h, input bit rdy, input bit clr);
    rvfi_valid    = v;
    rvfi_order    = ord;
    rvfi_halt     = h;
    rvfi_trap     = 1'($urandom_range(0, 1));
    rvfi_insn     = $urandom;
    rvfi_pc_rdata = $urandom;
    rvfi_rd_addr  = 5'($urandom_range(0, 31));
    rvfi_rd_wdata = $urandom;
    m_ready       = rdy;
    clear         = clr;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    rvfi_valid = 1'b0;
    rvfi_halt = 1'b0;
    m_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    logic [63:0] ord;
    bit v, h, rdy, clr;

    tbl[0] = '{1, 64'd0, 0, 0, 0, 1, 0, 0, 1, 64'd0};
    tbl[1] = '{1, 64'd1, 0, 0, 0, 2, 0, 0, 1, 64'd0};
    tbl[2] = '{0, 64'd0, 0, 1, 0, 1, 0, 0, 1, 64'd1};
    tbl[3] = '{1, 64'd2, 0, 1, 0, 1, 0, 0, 1, 64'd2};
    tbl[4] = '{0, 64'd0, 0, 1, 0, 0, 0, 0, 0, 64'd0};
    tbl[5] = '{1, 64'd3, 1, 0, 0, 1, 0, 1, 1, 64'd3};
    tbl[6] = '{1, 64'd4, 0, 0, 0, 1, 0, 1, 1, 64'd3};
    tbl[7] = '{1, 64'd5, 0, 1, 1, 0, 0, 0, 0, 64'd0};
    tbl[8] = '{1, 64'd6, 0, 1, 0, 1, 0, 0, 1, 64'd6};
    tbl[9] = '{0, 64'd0, 0, 1, 0, 0, 0, 0, 0, 64'd0};

    // Reset state and table vectors
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].ord, tbl[i].h, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_count", i),   64'(count),   64'(tbl[i].e_count));
      check($sformatf("tbl%0d_dropped", i), 64'(dropped), 64'(tbl[i].e_dropped));
      check($sformatf("tbl%0d_halted", i),  64'(halted),  64'(tbl[i].e_halted));
      check($sformatf("tbl%0d_mvalid", i),  64'(m_valid), 64'(tbl[i].e_mvalid));
      check($sformatf("tbl%0d_morder", i),  m_order,      tbl[i].e_morder);
    end

    // Stream: one entry per cycle, 1-cycle latency, no loss
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 64'(k), 0, 1, 0);
      check("stream_count_le1", 64'(count <= 1), 64'd1);
      check("stream_latency",   m_order, 64'(k));
    end
    drive(0, 0, 0, 1, 0);
    check("stream_dropped", 64'(dropped), 64'd0);
    check("stream_empty",   64'(m_valid), 64'd0);

    // Overflow, then full push+pop, then drain
    do_reset();
    for (int k = 0; k < 20; k++) drive(1, 64'(k), 0, 0, 0);
    check("ovf_count",   64'(count),   64'd16);
    check("ovf_dropped", 64'(dropped), 64'd4);
    check("ovf_head",    m_order,      64'd0);
    drive(0, 0, 0, 0, 0);
    check("ovf_head_stable", m_order, 64'd0);
    drive(1, 64'd20, 0, 1, 0);
    check("full_pp_count",   64'(count),   64'd16);
    check("full_pp_dropped", 64'(dropped), 64'd4);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", m_order, (i < 15) ? 64'(i + 1) : 64'd20);
      drive(0, 0, 0, 1, 0);
    end
    check("drain_count", 64'(count), 64'd0);

    // Halt stops capture without counting drops
    do_reset();
    drive(1, 64'd5, 1, 0, 0);
    drive(1, 64'd6, 0, 0, 0);
    drive(1, 64'd7, 0, 0, 0);
    check("halt_halted",  64'(halted),  64'd1);
    check("halt_count",   64'(count),   64'd1);
    check("halt_dropped", 64'(dropped), 64'd0);
    check("halt_head",    m_order,      64'd5);
    check("halt_flag",    64'(m_halt),  64'd1);

    // Order discontinuity
    do_reset();
    drive(1, 64'd0, 0, 1, 0);
    drive(1, 64'd1, 0, 1, 0);
    check("ord_no_err", 64'(order_err), 64'd0);
    drive(1, 64'd3, 0, 1, 0);
    check("ord_err", 64'(order_err), 64'(CHK));

    // Clear coinciding with a retirement
    do_reset();
    for (int k = 0; k < 17; k++) drive(1, 64'(k), 0, 0, 0);
    check("pre_clear_dropped", 64'(dropped), 64'd1);
    drive(1, 64'd17, 0, 1, 1);
    check("clear_count",   64'(count),   64'd0);
    check("clear_dropped", 64'(dropped), 64'd0);
    check("clear_mvalid",  64'(m_valid), 64'd0);

    // Asynchronous reset mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 64'(k), 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mvalid",  64'(m_valid), 64'd0);
    check("arst_count",   64'(count),   64'd0);
    check("arst_dropped", 64'(dropped), 64'd0);
    check("arst_halted",  64'(halted),  64'd0);
    check("arst_morder",  m_order,      64'd0);
    model_reset();
    rvfi_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();

    // Randomized traffic against the model
    do_reset();
    ord = '0;
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 2);
      h   = ($urandom_range(0, 199) < 1);
      if ($urandom_range(0, 99) < 3) ord = ord + 64'd2;
      drive(v, ord, h, rdy, clr);
      if (v) ord = ord + 64'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svc_rv_trace_fifo.md
# svc_rv_trace_fifo

Retirement trace buffer for the `svc_rv` core, sitting directly downstream of the core's RVFI port. It captures each retired instruction (order, PC, instruction word, rd write, trap/halt) into a FIFO and drains it through a valid/ready stream to a debug or host sink. It also counts retirements lost to overflow, and stops capturing after a halting instruction.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, 2..256.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`. Derived; do not override.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `clear`  in  1  synchronous clear of FIFO and status.
- `rvfi_valid`  in  1  retirement strobe.
- `rvfi_order`  in  64  retirement sequence number.
- `rvfi_insn`  in  32  instruction word.
- `rvfi_pc_rdata`  in  32  PC of the retired instruction.
- `rvfi_rd_addr`  in  5  destination register; 0 means no write.
- `rvfi_rd_wdata`  in  32  rd write data.
- `rvfi_trap`  in  1  trap flag.
- `rvfi_halt`  in  1  halt flag (ebreak).
- `m_valid`  out  1  trace entry available.
- `m_ready`  in  1  sink accepts the entry.
- `m_order`, `m_insn`, `m_pc`, `m_rd_addr`, `m_rd_wdata`, `m_trap`, `m_halt`  out  64/32/32/5/32/1/1  entry payload.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `dropped`  out  32  retirements lost to a full FIFO; saturating.
- `halted`  out  1  sticky; set once a halt entry has been accepted.
- `order_err`  out  1  sticky order-discontinuity flag.

## Operation
- Push condition: `rvfi_valid && !clear && !halted && (count<DEPTH || pop)`, where `pop = m_valid && m_ready`.
- Push while full with a simultaneous pop is accepted; `count` stays unchanged.
- Push refused because the FIFO is full and there is no pop: `dropped` increments and saturates at 0xFFFF_FFFF.
- While `halted=1`, `rvfi_valid` is ignored entirely: no push, no drop count.
- Accepted entry with `rvfi_halt=1`: `halted` sets on the same edge as the write.
- First-word-fall-through FIFO. Circular read and write pointers of `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
- `m_valid = (count != 0)`.
- All payload outputs are 0 whenever `m_valid=0`. Otherwise they show the entry at the read pointer.
- While `m_valid && !m_ready`, the payload holds stable.
- `clear` (synchronous, highest priority after reset) empties the FIFO and zeroes `dropped`, `halted` and `order_err`. Any input or pop in the same cycle is discarded.
- Order tracking keeps `last_order` and `have_last`. Every `rvfi_valid` seen while `!halted && !clear` (pushed or dropped) updates `last_order` and sets `have_last`.
- When `have_last` is already set, `rvfi_order != last_order+1` (64-bit wrap) sets `order_err`. The comparison is active only when the checker is compiled in; see Configuration.
- Storage RAM is not reset. All control state is reset.

## Timing
- Reset values: `m_valid=0`, all payload=0, `count=0`, `dropped=0`, `halted=0`, `order_err=0`, pointers=0, `have_last=0`.
- An entry pushed on edge N appears on `m_*` after edge N: 1-cycle latency, with no bypass in the same cycle.
- Pop occurs on the edge where `m_valid && m_ready`. The next entry, if any, is presented after that edge.
- `count`, `dropped`, `halted` and `order_err` update on the same edge as the event that causes them.
- Back-to-back `rvfi_valid` every cycle with `m_ready=1` sustains 1 entry/cycle with no loss.
- Reset assertion mid-stream clears everything immediately, without waiting for the clock. Deassertion is assumed synchronized upstream.

## Configuration
- Macro: `SVC_RV_TRACE_ORDER_CHECK_EN`.
- Defined: `last_order`/`have_last` are implemented and `order_err` behaves as described above.
- Undefined: the order logic is removed and `order_err` is tied to 0. The `order_err` port remains in both builds.

## Test plan
- Stream test: 20 retirements with order 0..19 and `m_ready=1` → 20 entries out in order, 1-cycle latency, `dropped=0`, `count` ≤ 1.
- Overflow: `DEPTH=16`, `m_ready=0`, 20 retirements → `count=16`. Then `dropped=4` and `m_order=0` held stable. After draining, the outputs are orders 0..15.
- Full with simultaneous push and pop: with `count=16`, `m_ready=1` and `rvfi_valid=1` → `count` stays 16, `dropped` is unchanged, and the new entry lands last.
- Halt: order 5 with `rvfi_halt=1`, then orders 6 and 7 → `halted=1`. Only entries up to 5 are queued and `dropped=0`.
- Order check (macro defined): orders 0, 1, 3 → `order_err=1` on the edge order 3 is seen. With the macro undefined, `order_err` stays 0.
- Clear and reset: `clear` pulse coinciding with `rvfi_valid` → `count=0`, all status zero, input discarded. An asynchronous `rst_n` low mid-burst → all outputs zero before the next edge.
